fm_demod: RTL

FM_DEMOD -- requirements
Module: fm_demod

---
 rtl/dsp_pkg.sv | 37 +++
 rtl/cordic_vec.sv | 90 +++++++++
 rtl/fm_demod.sv | 94 +++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP constants for the FM demodulator: widths, FSM encoding
// and the CORDIC arctangent table in 16-bit phase units.
package dsp_pkg;

  localparam int PW = 16;
  localparam int DW = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // round(atan(2^-i) * 65536 / (2*pi))
  function automatic logic [PW-1:0] atan_lut(input logic [3:0] i);
    logic [PW-1:0] r;
    unique case (i)
      4'd0:    r = 16'd8192;
      4'd1:    r = 16'd4836;
      4'd2:    r = 16'd2555;
      4'd3:    r = 16'd1297;
      4'd4:    r = 16'd651;
      4'd5:    r = 16'd326;
      4'd6:    r = 16'd163;
      4'd7:    r = 16'd81;
      4'd8:    r = 16'd41;
      4'd9:    r = 16'd20;
      4'd10:   r = 16'd10;
      4'd11:   r = 16'd5;
      4'd12:   r = 16'd3;
      4'd13:   r = 16'd1;
      default: r = 16'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cordic_vec.sv
// Iterative CORDIC vectoring engine: one pre-rotation cycle, then
// ITER micro-rotations driving y to zero while z accumulates the angle.
module cordic_vec
  import dsp_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    i_in,
  input  logic [7:0]    q_in,
  output logic          done,
  output logic [PW-1:0] z_out
);

  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic signed [DW-1:0] xs, ys;
  logic [PW-1:0]        z_q, z_d;
  logic [PW-1:0]        at;
  logic [3:0]           cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 pre_q, pre_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    cnt_d = cnt_q;
    run_d = run_q;
    pre_d = pre_q;
    done  = 1'b0;
    xs    = x_q >>> cnt_q;
    ys    = y_q >>> cnt_q;
    at    = atan_lut(cnt_q);
    if (start) begin
      // x4 scaling keeps -128 representable after negation
      x_d   = {{2{i_in[7]}}, i_in, 2'b00};
      y_d   = {{2{q_in[7]}}, q_in, 2'b00};
      z_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
      pre_d = 1'b1;
    end else if (run_q && pre_q) begin
      pre_d = 1'b0;
      if (x_q[DW-1]) begin
        x_d = -x_q;
        y_d = -y_q;
        z_d = 16'h8000;
      end
    end else if (run_q) begin
      if (!y_q[DW-1]) begin
        x_d = x_q + ys;
        y_d = y_q - xs;
        z_d = z_q + at;
      end else begin
        x_d = x_q - ys;
        y_d = y_q + xs;
        z_d = z_q - at;
      end
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(ITER - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      pre_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      pre_q <= pre_d;
    end
  end

  assign z_out = z_q;

endmodule

// File: rtl/fm_demod.sv
// FM demodulator: handshake and FSM around the CORDIC engine, output
// is the wrapped phase difference between consecutive samples.
module fm_demod
  import dsp_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         inphase,
  input  logic [7:0]         quadrature,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] audio,
  output logic               audio_valid
);

  state_e             state_q, state_d;
  logic [PW-1:0]      prev_q, prev_d;
  logic [PW-1:0]      phase;
  logic [PW-1:0]      cv_z;
  logic               first_q, first_d;
  logic               zero_q, zero_d;
  logic signed [15:0] audio_q, audio_d;
  logic               av_q, av_d;
  logic               start;
  logic               cv_done;

  cordic_vec #(.ITER(ITER)) u_cordic (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .i_in  (inphase),
    .q_in  (quadrature),
    .done  (cv_done),
    .z_out (cv_z)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    first_d = first_q;
    zero_d  = zero_q;
    audio_d = audio_q;
    av_d    = 1'b0;
    start   = 1'b0;
    // a zero vector has no phase; reuse the previous one
    phase   = zero_q ? prev_q : cv_z;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          start   = 1'b1;
          zero_d  = (inphase == 8'd0) && (quadrature == 8'd0);
          state_d = ROT;
        end
      end
      ROT: begin
        if (cv_done) state_d = OUT;
      end
      OUT: begin
        audio_d = first_q ? 16'sd0 : signed'(phase - prev_q);
        av_d    = 1'b1;
        prev_d  = phase;
        first_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      first_q <= 1'b1;
      zero_q  <= 1'b0;
      audio_q <= '0;
      av_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      zero_q  <= zero_d;
      audio_q <= audio_d;
      av_q    <= av_d;
    end
  end

  assign audio       = audio_q;
  assign audio_valid = av_q;

endmodule
